fibonacci_checker: RTL and testbench

Stream receiver that consumes the term sequence emitted by the team's Fibonacci generator and verifies it beat by beat. It tracks the last two accepted terms and predicts the next one. It flags the first mismatch with a sticky error and the captured values, and reports when the sequence is exhausted at the WIDTH limit. It sits at the consumer end of the generator's output, both in silicon self-check and as a reusable bench monitor.

---
 rtl/fibonacci_checker_pkg.sv | 30 +++
 rtl/fibonacci_checker_predictor.sv | 34 +++
 rtl/fibonacci_checker.sv | 139 +++++++++++++
 tb/tb_fibonacci_checker.sv | 314 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fibonacci_checker_pkg.sv
// Shared definitions for the Fibonacci generator, checker and benches.
package fibonacci_checker_pkg;

    typedef enum logic [2:0] {
        SEED0,
        SEED1,
        TRACK,
        END,
        ERR
    } fib_state_t;

    // Number of terms (starting 0, 1) that fit before the next sum overflows.
    function automatic int fib_max_terms(input int width);
        longint a;
        longint b;
        longint c;
        int n;
        a = 0;
        b = 1;
        n = 2;
        while (a + b < (longint'(1) << width)) begin
            c = a + b;
            a = b;
            b = c;
            n++;
        end
        return n;
    endfunction

endpackage

// File: rtl/fibonacci_checker_predictor.sv
// Last-two-terms register pair with the next-term adder.
module fib_predictor #(
    parameter int WIDTH = 10
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             ld,
    input  logic             sh,
    input  logic [WIDTH-1:0] data,
    output logic [WIDTH:0]   sum,
    output logic             ovf
);

    logic [WIDTH-1:0] f0;
    logic [WIDTH-1:0] f1;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            f0 <= '0;
            f1 <= '0;
        end else if (sh) begin
            f0 <= f1;
            f1 <= data;
        end else if (ld) begin
            f1 <= data;
        end
    end

    assign sum = {1'b0, f0} + {1'b0, f1};

    // Lookahead: would the pair after shifting in data overflow on its sum.
    assign ovf = |(({1'b0, f1} + {1'b0, data}) >> WIDTH);

endmodule

// File: rtl/fibonacci_checker.sv
// Stream checker for the Fibonacci generator: seed, track, end-of-range and
// sticky mismatch capture.
module fibonacci_checker
    import fibonacci_checker_pkg::*;
#(
    parameter int WIDTH       = 10,
    parameter int CNT_W       = 8,
    parameter bit STRICT_SEED = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in_data,
    output logic             in_ready,
    output logic             locked,
    output logic             done,
    output logic             err,
    output logic [WIDTH-1:0] err_data,
    output logic [WIDTH-1:0] err_exp,
    output logic [CNT_W-1:0] term_cnt
);

    fib_state_t state;
    fib_state_t state_nxt;

    logic             acc;
    logic             ld;
    logic             sh;
    logic             fail;
    logic [WIDTH-1:0] exp_val;
    logic [WIDTH:0]   sum;
    logic             ovf;

    assign in_ready = !clr && (state != ERR);
    assign acc      = in_valid && in_ready;

    fib_predictor #(
        .WIDTH(WIDTH)
    ) u_pred (
        .clk (clk),
        .rst (rst),
        .ld  (ld),
        .sh  (sh),
        .data(in_data),
        .sum (sum),
        .ovf (ovf)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= SEED0;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        ld        = 1'b0;
        sh        = 1'b0;
        fail      = 1'b0;
        exp_val   = '0;
        if (clr) begin
            state_nxt = SEED0;
        end else if (acc) begin
            unique case (state)
                SEED0, END: begin
                    if (STRICT_SEED && in_data != '0) begin
                        fail = 1'b1;
                    end else begin
                        ld        = 1'b1;
                        state_nxt = SEED1;
                    end
                end
                SEED1: begin
                    exp_val = WIDTH'(1);
                    if (STRICT_SEED && in_data != WIDTH'(1)) begin
                        fail = 1'b1;
                    end else begin
                        sh        = 1'b1;
                        state_nxt = TRACK;
                    end
                end
                TRACK: begin
                    exp_val = sum[WIDTH-1:0];
                    // A sum that no longer fits can never be matched.
                    if ({1'b0, in_data} != sum) begin
                        fail = 1'b1;
                    end else begin
                        sh        = 1'b1;
                        state_nxt = ovf ? END : TRACK;
                    end
                end
                default: ;
            endcase
            if (fail) begin
                state_nxt = ERR;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            locked   <= 1'b0;
            done     <= 1'b0;
            err      <= 1'b0;
            err_data <= '0;
            err_exp  <= '0;
            term_cnt <= '0;
        end else if (clr) begin
            locked   <= 1'b0;
            done     <= 1'b0;
            err      <= 1'b0;
            term_cnt <= '0;
        end else if (acc) begin
            if (state == END) begin
                done   <= 1'b0;
                locked <= 1'b0;
            end
            if (fail) begin
                err      <= 1'b1;
                err_data <= in_data;
                err_exp  <= exp_val;
            end else begin
                if (term_cnt != '1) begin
                    term_cnt <= term_cnt + 1'b1;
                end
                if (state == SEED1) begin
                    locked <= 1'b1;
                end
                if (state_nxt == END) begin
                    done <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_fibonacci_checker.sv
// Scoreboard bench for fibonacci_checker with a behavioural reference model.
module tb_fibonacci_checker;
    import fibonacci_checker_pkg::*;

    localparam int W  = 10;
    localparam int CW = 8;
    localparam int MAXV = (1 << W) - 1;

    logic          clk = 1'b0;
    logic          rst;
    logic          clr;
    logic          in_valid;
    logic [W-1:0]  in_data;
    logic          in_ready;
    logic          locked;
    logic          done;
    logic          err;
    logic [W-1:0]  err_data;
    logic [W-1:0]  err_exp;
    logic [CW-1:0] term_cnt;

    always #5 clk = ~clk;

    fibonacci_checker #(
        .WIDTH      (W),
        .CNT_W      (CW),
        .STRICT_SEED(1'b1)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .clr     (clr),
        .in_valid(in_valid),
        .in_data (in_data),
        .in_ready(in_ready),
        .locked  (locked),
        .done    (done),
        .err     (err),
        .err_data(err_data),
        .err_exp (err_exp),
        .term_cnt(term_cnt)
    );

    typedef struct {
        logic          rdy;
        logic          lk;
        logic          dn;
        logic          er;
        logic [W-1:0]  ed;
        logic [W-1:0]  ee;
        logic [CW-1:0] cnt;
    } exp_t;

    exp_t exp_q[$];
    int   n_chk = 0;
    int   n_err = 0;

    fib_state_t m_st;
    int         m_f0;
    int         m_f1;
    int         m_cnt;
    logic       m_lk;
    logic       m_dn;
    logic       m_er;
    logic [W-1:0] m_ed;
    logic [W-1:0] m_ee;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic m_reset();
        m_st  = SEED0;
        m_f0  = 0;
        m_f1  = 0;
        m_cnt = 0;
        m_lk  = 1'b0;
        m_dn  = 1'b0;
        m_er  = 1'b0;
        m_ed  = '0;
        m_ee  = '0;
    endtask

    task automatic m_fail(input int d, input int e);
        m_st = ERR;
        m_er = 1'b1;
        m_ed = d[W-1:0];
        m_ee = e[W-1:0];
    endtask

    task automatic m_ok();
        if (m_cnt < (1 << CW) - 1) m_cnt++;
    endtask

    task automatic model(input logic v, input int d, input logic c);
        if (c) begin
            m_st  = SEED0;
            m_er  = 1'b0;
            m_dn  = 1'b0;
            m_lk  = 1'b0;
            m_cnt = 0;
        end else if (v && m_st != ERR) begin
            if (m_st == SEED0 || m_st == END) begin
                m_dn = 1'b0;
                m_lk = 1'b0;
                if (d != 0) begin
                    m_fail(d, 0);
                end else begin
                    m_f1 = d;
                    m_st = SEED1;
                    m_ok();
                end
            end else if (m_st == SEED1) begin
                if (d != 1) begin
                    m_fail(d, 1);
                end else begin
                    m_f0 = m_f1;
                    m_f1 = d;
                    m_st = TRACK;
                    m_lk = 1'b1;
                    m_ok();
                end
            end else begin
                if (d != m_f0 + m_f1) begin
                    m_fail(d, (m_f0 + m_f1) & MAXV);
                end else begin
                    m_f0 = m_f1;
                    m_f1 = d;
                    m_ok();
                    if (m_f0 + m_f1 > MAXV) begin
                        m_st = END;
                        m_dn = 1'b1;
                    end
                end
            end
        end
    endtask

    task automatic step(input logic v, input int d, input logic c);
        exp_t e;
        @(negedge clk);
        in_valid = v;
        in_data  = d[W-1:0];
        clr      = c;
        model(v, d, c);
        e.rdy = !c && (m_st != ERR);
        e.lk  = m_lk;
        e.dn  = m_dn;
        e.er  = m_er;
        e.ed  = m_ed;
        e.ee  = m_ee;
        e.cnt = m_cnt[CW-1:0];
        exp_q.push_back(e);
    endtask

    task automatic settle();
        @(posedge clk);
        #3;
    endtask

    task automatic send(input int d, input bit gaps);
        if (gaps) begin
            repeat ($urandom_range(0, 2)) step(1'b0, $urandom_range(0, MAXV), 1'b0);
        end
        step(1'b1, d, 1'b0);
    endtask

    task automatic feed_fib(input int last, input bit gaps);
        int a;
        int b;
        int c;
        a = 0;
        b = 1;
        send(a, gaps);
        send(b, gaps);
        while (a + b <= last) begin
            c = a + b;
            a = b;
            b = c;
            send(c, gaps);
        end
    endtask

    always @(posedge clk) begin
        #2;
        if (exp_q.size() > 0) begin
            exp_t e;
            e = exp_q.pop_front();
            chk("sb_rdy", in_ready, e.rdy);
            chk("sb_lock", locked, e.lk);
            chk("sb_done", done, e.dn);
            chk("sb_err", err, e.er);
            chk("sb_edata", err_data, e.ed);
            chk("sb_eexp", err_exp, e.ee);
            chk("sb_cnt", term_cnt, e.cnt);
        end
    end

    int seq1[7] = '{0, 1, 1, 2, 3, 5, 8};
    int seq3[5] = '{0, 1, 1, 2, 4};

    initial begin
        rst      = 1'b1;
        clr      = 1'b0;
        in_valid = 1'b0;
        in_data  = '0;
        m_reset();
        repeat (2) @(posedge clk);
        #1;
        chk("rst_lock", locked, 0);
        chk("rst_done", done, 0);
        chk("rst_err", err, 0);
        chk("rst_edata", err_data, 0);
        chk("rst_eexp", err_exp, 0);
        chk("rst_cnt", term_cnt, 0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("rst_rdy", in_ready, 1);

        foreach (seq1[i]) step(1'b1, seq1[i], 1'b0);
        settle();
        chk("t1_cnt", term_cnt, 7);
        chk("t1_lock", locked, 1);
        chk("t1_err", err, 0);

        step(1'b0, 0, 1'b1);
        feed_fib(987, 1'b0);
        settle();
        chk("t2_done", done, 1);
        chk("t2_cnt", term_cnt, fib_max_terms(W));
        step(1'b1, 0, 1'b0);
        step(1'b1, 1, 1'b0);
        settle();
        chk("t2_redone", done, 0);
        chk("t2_relock", locked, 1);
        chk("t2_recnt", term_cnt, 19);

        step(1'b0, 0, 1'b1);
        foreach (seq3[i]) step(1'b1, seq3[i], 1'b0);
        settle();
        chk("t3_err", err, 1);
        chk("t3_edata", err_data, 4);
        chk("t3_eexp", err_exp, 3);
        chk("t3_rdy", in_ready, 0);
        chk("t3_cnt", term_cnt, 4);
        step(1'b0, 0, 1'b1);
        step(1'b0, 0, 1'b0);
        settle();
        chk("t3_clr_err", err, 0);
        chk("t3_clr_rdy", in_ready, 1);
        chk("t3_clr_state", dut.state, SEED0);
        chk("t3_clr_cnt", term_cnt, 0);

        step(1'b1, 5, 1'b0);
        settle();
        chk("t4_err", err, 1);
        chk("t4_edata", err_data, 5);
        chk("t4_eexp", err_exp, 0);
        step(1'b0, 0, 1'b1);
        step(1'b1, 0, 1'b0);
        step(1'b1, 2, 1'b0);
        settle();
        chk("t4_s1_edata", err_data, 2);
        chk("t4_s1_eexp", err_exp, 1);

        step(1'b0, 0, 1'b1);
        step(1'b1, 0, 1'b1);
        settle();
        chk("t5_clrbeat_cnt", term_cnt, 0);
        feed_fib(21, 1'b1);
        settle();
        chk("t5_err", err, 0);
        chk("t5_cnt", term_cnt, 9);

        step(1'b0, 0, 1'b1);
        repeat (16) feed_fib(987, 1'b0);
        settle();
        chk("sat_cnt", term_cnt, (1 << CW) - 1);
        chk("sat_done", done, 1);

        step(1'b0, 0, 1'b1);
        step(1'b1, 0, 1'b0);
        step(1'b1, 1, 1'b0);
        step(1'b1, 1, 1'b0);
        @(posedge clk);
        #3;
        rst = 1'b1;
        m_reset();
        #1;
        chk("arst_lock", locked, 0);
        chk("arst_done", done, 0);
        chk("arst_err", err, 0);
        chk("arst_edata", err_data, 0);
        chk("arst_eexp", err_exp, 0);
        chk("arst_cnt", term_cnt, 0);
        @(negedge clk);
        rst      = 1'b0;
        in_valid = 1'b0;
        #1;
        chk("arst_rdy", in_ready, 1);
        step(1'b1, 0, 1'b0);
        settle();
        chk("arst_cnt1", term_cnt, 1);

        repeat (2) @(posedge clk);
        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
